// File: rtl/counter_mod_presc_if.sv
// Control and status bundle for the prescaled modulo counter.
interface counter_mod_presc_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PRESC_W = 16
);

  // Control inputs to the counter
  logic               en;
  logic               up;
  logic               clr;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   modulo;
  logic [PRESC_W-1:0] div;
  logic [WIDTH-1:0]   cmp_val;

  // Status outputs from the counter
  logic [WIDTH-1:0]   q;
  logic               tick;
  logic               tc;
  logic               ovf;
  logic               cmp_match;

  // Side that owns the control inputs and observes the counter
  modport master (
    output en, up, clr, load, load_val, modulo, div, cmp_val,
    input  q, tick, tc, ovf, cmp_match
  );

  // Counter side
  modport slave (
    input  en, up, clr, load, load_val, modulo, div, cmp_val,
    output q, tick, tc, ovf, cmp_match
  );

endinterface

// File: rtl/counter_mod_presc.sv
// Parametrised up/down counter with prescaler, modulo wrap, clear, load,
// terminal-count pulse, sticky overflow and compare match.
module counter_mod_presc #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  counter_mod_presc_if.slave    bus
);

  // Elaboration-time sanity on parameters
  if (WIDTH < 2) begin : g_bad_width
    $error("counter_mod_presc: WIDTH must be >= 2");
  end
  if (PRESC_W < 1) begin : g_bad_presc
    $error("counter_mod_presc: PRESC_W must be >= 1");
  end

  // Registered state
  logic [WIDTH-1:0]   q_r;
  logic [PRESC_W-1:0] pcnt_r;
  logic               tick_r;
  logic               tc_r;
  logic               ovf_r;

  // Next-state values
  logic [WIDTH-1:0]   q_nxt;
  logic [PRESC_W-1:0] pcnt_nxt;
  logic               tick_nxt;
  logic               tc_nxt;
  logic               ovf_nxt;

  // Step decision and the value a step would produce
  logic               step_c;
  logic               wrap_c;
  logic [WIDTH-1:0]   q_step_c;

  // Prescaler: a step fires once pcnt has reached div; >= also covers div
  // being lowered below the running count
  always_comb begin
    step_c   = 1'b0;
    pcnt_nxt = pcnt_r;
    if (bus.en) begin
      if (pcnt_r >= bus.div) begin
        step_c   = 1'b1;
        pcnt_nxt = '0;
      end else begin
        pcnt_nxt = pcnt_r + PRESC_W'(1);
      end
    end
  end

  // Stepped counter value and wrap detection in either direction
  always_comb begin
    wrap_c   = 1'b0;
    q_step_c = q_r;
    if (bus.up) begin
      if (q_r >= bus.modulo) begin
        wrap_c   = 1'b1;
        q_step_c = '0;
      end else begin
        q_step_c = q_r + WIDTH'(1);
      end
    end else begin
      if (q_r == '0) begin
        wrap_c   = 1'b1;
        q_step_c = bus.modulo;
      end else begin
        q_step_c = q_r - WIDTH'(1);
      end
    end
  end

  // Next state with clr > load > step priority
  always_comb begin
    q_nxt    = q_r;
    tick_nxt = 1'b0;
    tc_nxt   = 1'b0;
    ovf_nxt  = ovf_r;
    if (bus.clr) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (bus.load) begin
      q_nxt = bus.load_val;
    end else if (step_c) begin
      q_nxt    = q_step_c;
      tick_nxt = 1'b1;
      tc_nxt   = wrap_c;
      ovf_nxt  = ovf_r | wrap_c;
    end
  end

  // State register; clr and load also restart the prescaler
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= '0;
      pcnt_r <= '0;
      tick_r <= 1'b0;
      tc_r   <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      pcnt_r <= (bus.clr || bus.load) ? '0 : pcnt_nxt;
      tick_r <= tick_nxt;
      tc_r   <= tc_nxt;
      ovf_r  <= ovf_nxt;
    end
  end

  // Output drive; cmp_match is intentionally combinational on q
  assign bus.q         = q_r;
  assign bus.tick      = tick_r;
  assign bus.tc        = tc_r;
  assign bus.ovf       = ovf_r;
  assign bus.cmp_match = (q_r == bus.cmp_val);

endmodule

// File: tb/tb_counter_mod_presc.sv
// Scoreboard bench for counter_mod_presc: directed vectors push expected
// post-edge state; a monitor pops and compares after every rising edge.
module tb_counter_mod_presc;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned PRESC_W = 16;
  localparam logic [WIDTH-1:0] MAXV = 32'hFFFF_FFFF;

  logic clk;
  logic rst;

  counter_mod_presc_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

  counter_mod_presc #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int               id;
    logic [WIDTH-1:0] q;
    logic             tick;
    logic             tc;
    logic             ovf;
    logic             cm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;
  bit   done   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and push the hand-computed post-edge state
  task automatic v(input logic r, input logic e, input logic u, input logic c,
                   input logic l, input logic [WIDTH-1:0] lv,
                   input logic [WIDTH-1:0] md, input logic [PRESC_W-1:0] d,
                   input logic [WIDTH-1:0] cv, input logic [WIDTH-1:0] eq,
                   input logic et, input logic etc, input logic eo);
    exp_t x;
    @(negedge clk);
    rst = r; bus.en = e; bus.up = u; bus.clr = c; bus.load = l;
    bus.load_val = lv; bus.modulo = md; bus.div = d; bus.cmp_val = cv;
    x.id = vec_id; x.q = eq; x.tick = et; x.tc = etc; x.ovf = eo;
    x.cm = (eq == cv);
    sb.push_back(x);
    vec_id++;
  endtask

  // Monitor: compare every field after each rising edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (bus.q !== x.q) begin
          errors++;
          $display("FAIL q vec%0d: got %0h expected %0h", x.id, bus.q, x.q);
        end
        checks++;
        if (bus.tick !== x.tick) begin
          errors++;
          $display("FAIL tick vec%0d: got %b expected %b", x.id, bus.tick, x.tick);
        end
        checks++;
        if (bus.tc !== x.tc) begin
          errors++;
          $display("FAIL tc vec%0d: got %b expected %b", x.id, bus.tc, x.tc);
        end
        checks++;
        if (bus.ovf !== x.ovf) begin
          errors++;
          $display("FAIL ovf vec%0d: got %b expected %b", x.id, bus.ovf, x.ovf);
        end
        checks++;
        if (bus.cmp_match !== x.cm) begin
          errors++;
          $display("FAIL cmp_match vec%0d: got %b expected %b", x.id, bus.cmp_match, x.cm);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.up = 1'b1; bus.clr = 1'b0; bus.load = 1'b0;
    bus.load_val = '0; bus.modulo = MAXV; bus.div = '0; bus.cmp_val = '0;

    // 1: reset, then legacy free-running count and full roll-over
    //  r e u c l lv    mod   d cv   q     t tc o
    v(1,0,1,0,0, 0,    MAXV, 0, 0,   0,    0,0,0);
    v(1,1,1,0,0, 0,    MAXV, 0, 0,   0,    0,0,0);
    v(0,1,1,0,0, 0,    MAXV, 0, 0,   1,    1,0,0);
    v(0,1,1,0,0, 0,    MAXV, 0, 0,   2,    1,0,0);
    v(0,1,1,0,0, 0,    MAXV, 0, 0,   3,    1,0,0);
    v(0,1,1,0,1, MAXV, MAXV, 0, 0,   MAXV, 0,0,0);
    v(0,1,1,0,0, 0,    MAXV, 0, 0,   0,    1,1,1);
    v(0,0,1,1,0, 0,    MAXV, 0, 0,   0,    0,0,0);

    // 2: modulo 4 up-count with compare at 3
    v(0,1,1,0,0, 0, 4, 0, 3,   1, 1,0,0);
    v(0,1,1,0,0, 0, 4, 0, 3,   2, 1,0,0);
    v(0,1,1,0,0, 0, 4, 0, 3,   3, 1,0,0);
    v(0,1,1,0,0, 0, 4, 0, 3,   4, 1,0,0);
    v(0,1,1,0,0, 0, 4, 0, 3,   0, 1,1,1);
    v(0,1,1,0,0, 0, 4, 0, 3,   1, 1,0,1);
    v(0,0,1,1,0, 0, 4, 0, 3,   0, 0,0,0);

    // 3: div=2 prescale, enable gap, then div lowered below pcnt
    v(0,1,1,0,0, 0, 9, 2, 0,   0, 0,0,0);
    v(0,1,1,0,0, 0, 9, 2, 0,   0, 0,0,0);
    v(0,1,1,0,0, 0, 9, 2, 0,   1, 1,0,0);
    v(0,1,1,0,0, 0, 9, 2, 0,   1, 0,0,0);
    for (int i = 0; i < 5; i++) v(0,0,1,0,0, 0, 9, 2, 0,   1, 0,0,0);
    v(0,1,1,0,0, 0, 9, 2, 0,   1, 0,0,0);
    v(0,1,1,0,0, 0, 9, 2, 0,   2, 1,0,0);
    v(0,1,1,0,0, 0, 9, 2, 0,   2, 0,0,0);
    v(0,1,1,0,0, 0, 9, 0, 0,   3, 1,0,0);
    v(0,0,1,1,0, 0, 9, 0, 0,   0, 0,0,0);

    // 4: down-count wrap, load above modulo, wrap up and plain decrement
    v(0,0,0,0,1, 1,  5, 0, 0,   1,  0,0,0);
    v(0,1,0,0,0, 0,  5, 0, 0,   0,  1,0,0);
    v(0,1,0,0,0, 0,  5, 0, 0,   5,  1,1,1);
    v(0,0,0,0,1, 20, 5, 0, 0,   20, 0,0,1);
    v(0,1,1,0,0, 0,  5, 0, 0,   0,  1,1,1);
    v(0,0,0,0,1, 20, 5, 0, 0,   20, 0,0,1);
    v(0,1,0,0,0, 0,  5, 0, 0,   19, 1,0,1);

    // 5: clr beats load; load beats a pending step; modulo 0
    v(0,1,1,1,1, 7, 0, 0, 0,   0, 0,0,0);
    v(0,1,1,0,1, 7, 0, 0, 0,   7, 0,0,0);
    v(0,1,1,0,0, 0, 0, 0, 0,   0, 1,1,1);
    v(0,1,1,0,0, 0, 0, 0, 0,   0, 1,1,1);
    v(0,1,0,0,0, 0, 0, 0, 0,   0, 1,1,1);

    // 6: reset mid-count overrides clr/load/en, then hold
    v(0,1,1,0,0, 0, 9, 0, 2,   1, 1,0,1);
    v(1,1,1,1,1, 9, 9, 0, 2,   0, 0,0,0);
    v(0,0,1,0,0, 0, 9, 0, 2,   0, 0,0,0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
